fifo_sync_flags: RTL and testbench

- Parametrised single-clock FIFO; successor to the dual-clock fifo1 for same-domain datapaths.
- Depth is 2^ASIZE. Provides programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
- Read mode is selectable: registered output (FWFT=0) or first-word-fall-through (FWFT=1).
- Drops in wherever producer and consumer share `clk`.

---
 rtl/fifo_sync_flags.sv | 162 ++++++++++++++++
 tb/tb_fifo_sync_flags.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags
// ---------------
// Single-clock FIFO with DEPTH = 2**ASIZE entries. It has registered full, empty,
// almost-full and almost-empty flags, an occupancy count, and sticky
// overflow/underflow error flags. The read path is either a registered output
// (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Ports:
//   clk           in   single clock, all logic on the rising edge
//   rst           in   synchronous active-high reset, highest priority
//   wdata         in   [DSIZE-1:0] write data
//   winc          in   write request, ignored while wfull
//   wfull         out  count == DEPTH
//   walmost_full  out  count >= AFULL_LVL
//   rinc          in   read request, ignored while rempty
//   rdata         out  [DSIZE-1:0] read data (registered or fall-through)
//   rempty        out  count == 0
//   ralmost_empty out  count <= AEMPTY_LVL
//   count         out  [ASIZE:0] occupancy, 0..DEPTH
//   overflow      out  sticky, a write was attempted while full
//   underflow     out  sticky, a read was attempted while empty

module fifo_sync_flags #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = (1 << ASIZE) - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH      = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_CNT  = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] AFULL_CNT  = AFULL_LVL[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_CNT = AEMPTY_LVL[ASIZE:0];
  localparam logic [ASIZE:0] CNT_ZERO   = {(ASIZE+1){1'b0}};
  localparam logic [ASIZE:0] CNT_ONE    = (ASIZE+1)'(1'b1);
  localparam logic [ASIZE-1:0] PTR_ONE  = ASIZE'(1'b1);

  // Storage is intentionally left unreset.
  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE-1:0] wptr_q, wptr_d;
  logic [ASIZE-1:0] rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             wfull_q, wfull_d;
  logic             rempty_q, rempty_d;
  logic             walmost_full_q, walmost_full_d;
  logic             ralmost_empty_q, ralmost_empty_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_en_s;
  logic             rd_en_s;

  // Accept decisions, next-state pointers, count, flags and read register.
  always_comb begin
    wr_en_s         = winc & ~wfull_q;
    rd_en_s         = rinc & ~rempty_q;
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    count_d         = count_q;
    rdata_d         = rdata_q;

    if (wr_en_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end

    if (rd_en_s) begin
      rptr_d  = rptr_q + PTR_ONE;
      rdata_d = mem_q[rptr_q];
    end else begin
      rptr_d  = rptr_q;
      rdata_d = rdata_q;
    end

    // A simultaneous accepted write and read leave the occupancy unchanged.
    if (wr_en_s && !rd_en_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_en_s && rd_en_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end

    // The flags are registered copies of what the count will be after this edge.
    wfull_d         = (count_d == DEPTH_CNT);
    rempty_d        = (count_d == CNT_ZERO);
    walmost_full_d  = (count_d >= AFULL_CNT);
    ralmost_empty_d = (count_d <= AEMPTY_CNT);

    overflow_d      = overflow_q  | (winc & wfull_q);
    underflow_d     = underflow_q | (rinc & rempty_q);
  end

  // Control and status registers, with reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q          <= {ASIZE{1'b0}};
      rptr_q          <= {ASIZE{1'b0}};
      count_q         <= CNT_ZERO;
      wfull_q         <= 1'b0;
      rempty_q        <= 1'b1;
      walmost_full_q  <= 1'b0;
      ralmost_empty_q <= 1'b1;
      rdata_q         <= {DSIZE{1'b0}};
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      wfull_q         <= wfull_d;
      rempty_q        <= rempty_d;
      walmost_full_q  <= walmost_full_d;
      ralmost_empty_q <= ralmost_empty_d;
      rdata_q         <= rdata_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
    end
  end

  // Storage write. This is blocked during reset so that no write lands on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Read data source. In fall-through mode the head entry is shown directly.
  always_comb begin
    if (FWFT != 0) begin
      rdata = mem_q[rptr_q];
    end else begin
      rdata = rdata_q;
    end
  end

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = walmost_full_q;
  assign ralmost_empty = ralmost_empty_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed testbench for fifo_sync_flags. One instance uses a registered read path
// and a second instance uses fall-through. Both are 4 deep, with AFULL_LVL=3 and AEMPTY_LVL=1.

module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wdata_a, wdata_b;
  logic       winc_a, rinc_a, winc_b, rinc_b;
  logic [7:0] rdata_a, rdata_b;
  logic       wfull_a, walmost_full_a, rempty_a, ralmost_empty_a, overflow_a, underflow_a;
  logic       wfull_b, walmost_full_b, rempty_b, ralmost_empty_b, overflow_b, underflow_b;
  logic [2:0] count_a, count_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DSIZE(8), .ASIZE(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .wdata(wdata_a), .winc(winc_a), .wfull(wfull_a),
    .walmost_full(walmost_full_a), .rinc(rinc_a), .rdata(rdata_a), .rempty(rempty_a),
    .ralmost_empty(ralmost_empty_a), .count(count_a), .overflow(overflow_a),
    .underflow(underflow_a)
  );

  fifo_sync_flags #(.DSIZE(8), .ASIZE(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata_b), .winc(winc_b), .wfull(wfull_b),
    .walmost_full(walmost_full_b), .rinc(rinc_b), .rdata(rdata_b), .rempty(rempty_b),
    .ralmost_empty(ralmost_empty_b), .count(count_b), .overflow(overflow_b),
    .underflow(underflow_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full flag vector of the registered instance: {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow}.
  function automatic logic [7:0] flags_a();
    return {2'b00, wfull_a, walmost_full_a, rempty_a, ralmost_empty_a, overflow_a, underflow_a};
  endfunction

  task automatic wr_a(input logic [7:0] d);
    winc_a = 1'b1; wdata_a = d; step(); winc_a = 1'b0;
  endtask

  task automatic rd_a();
    rinc_a = 1'b1; step(); rinc_a = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] d;
  logic [7:0] e;

  initial begin
    rst = 1'b1; winc_a = 1'b0; rinc_a = 1'b0; winc_b = 1'b0; rinc_b = 1'b0;
    wdata_a = 8'h00; wdata_b = 8'h00;

    // Reset state
    step(); step();
    chk("rst_count", 8'(count_a), 8'd0);
    chk("rst_flags", flags_a(), 8'b0000_1100);
    chk("rst_rdata", rdata_a, 8'h00);
    chk("rst_fwft_flags", {4'h0, wfull_b, rempty_b, overflow_b, underflow_b}, 8'b0000_0100);
    rst = 1'b0;
    step();

    // Fill: count 1..4, almost-full at 3, full at 4
    wr_a(8'h11);
    chk("fill1_count", 8'(count_a), 8'd1);
    chk("fill1_flags", flags_a(), 8'b0000_0100);
    wr_a(8'h22);
    chk("fill2_count", 8'(count_a), 8'd2);
    chk("fill2_flags", flags_a(), 8'b0000_0000);
    wr_a(8'h33);
    chk("fill3_count", 8'(count_a), 8'd3);
    chk("fill3_flags", flags_a(), 8'b0001_0000);
    wr_a(8'h44);
    chk("fill4_count", 8'(count_a), 8'd4);
    chk("fill4_flags", flags_a(), 8'b0011_0000);

    // Drain: the data word is valid straight after the read edge
    rd_a(); chk("drain1_rdata", rdata_a, 8'h11); chk("drain1_count", 8'(count_a), 8'd3);
    rd_a(); chk("drain2_rdata", rdata_a, 8'h22); chk("drain2_count", 8'(count_a), 8'd2);
    rd_a(); chk("drain3_rdata", rdata_a, 8'h33); chk("drain3_count", 8'(count_a), 8'd1);
    rd_a(); chk("drain4_rdata", rdata_a, 8'h44);
    chk("drain4_count", 8'(count_a), 8'd0);
    chk("drain4_flags", flags_a(), 8'b0000_1100);
    step();
    chk("idle_rdata_hold", rdata_a, 8'h44);

    // Wrap-around: 10 bursts of write-2/read-1. Writes that arrive while full are dropped.
    d = 8'h80;
    for (int b = 0; b < 10; b++) begin
      for (int w = 0; w < 2; w++) begin
        wr_a(d);
        if (q.size() < 4) q.push_back(d);
        d = d + 8'h01;
        chk("wrap_wr_count", 8'(count_a), 8'(q.size()));
      end
      rd_a();
      e = q.pop_front();
      chk("wrap_rd_data", rdata_a, e);
      chk("wrap_rd_count", 8'(count_a), 8'(q.size()));
    end
    chk("wrap_overflow", 8'(overflow_a), 8'd1);

    // Reset clears the overflow produced by the wrap phase
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_count", 8'(count_a), 8'd0);
    chk("rst2_flags", flags_a(), 8'b0000_1100);
    chk("rst2_rdata", rdata_a, 8'h00);

    // Collision while full: the read is accepted and the write is dropped
    wr_a(8'hA0); wr_a(8'hA1); wr_a(8'hA2); wr_a(8'hA3);
    winc_a = 1'b1; rinc_a = 1'b1; wdata_a = 8'hEE; step(); winc_a = 1'b0; rinc_a = 1'b0;
    chk("full_col_rdata", rdata_a, 8'hA0);
    chk("full_col_count", 8'(count_a), 8'd3);
    chk("full_col_flags", flags_a(), 8'b0001_0010);
    rd_a(); chk("full_col_d1", rdata_a, 8'hA1);
    rd_a(); chk("full_col_d2", rdata_a, 8'hA2);
    rd_a(); chk("full_col_d3", rdata_a, 8'hA3);
    chk("full_col_empty", 8'(rempty_a), 8'd1);

    // Collision while empty: the write is accepted and the read is rejected, so rdata holds
    winc_a = 1'b1; rinc_a = 1'b1; wdata_a = 8'hA5; step(); winc_a = 1'b0; rinc_a = 1'b0;
    chk("empty_col_count", 8'(count_a), 8'd1);
    chk("empty_col_flags", flags_a(), 8'b0000_0111);
    chk("empty_col_rdata", rdata_a, 8'hA3);
    rd_a();
    chk("empty_col_read", rdata_a, 8'hA5);
    chk("empty_col_count2", 8'(count_a), 8'd0);
    step(); step();
    chk("sticky_flags", {6'd0, overflow_a, underflow_a}, 8'b0000_0011);

    // Reset mid-operation with 3 entries stored
    wr_a(8'h01); wr_a(8'h02); wr_a(8'h03);
    chk("mid_count_pre", 8'(count_a), 8'd3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_count", 8'(count_a), 8'd0);
    chk("mid_rst_flags", flags_a(), 8'b0000_1100);
    wr_a(8'h77);
    rd_a();
    chk("mid_rdata", rdata_a, 8'h77);
    chk("mid_count", 8'(count_a), 8'd0);

    // Fall-through: data appears without a read request
    winc_b = 1'b1; wdata_b = 8'h5A; step(); winc_b = 1'b0;
    chk("fwft_rempty", 8'(rempty_b), 8'd0);
    chk("fwft_rdata", rdata_b, 8'h5A);
    winc_b = 1'b1; wdata_b = 8'h6B; step(); winc_b = 1'b0;
    chk("fwft_head_hold", rdata_b, 8'h5A);
    chk("fwft_count2", 8'(count_b), 8'd2);
    rinc_b = 1'b1; step(); rinc_b = 1'b0;
    chk("fwft_next", rdata_b, 8'h6B);
    chk("fwft_count1", 8'(count_b), 8'd1);
    rinc_b = 1'b1; step(); rinc_b = 1'b0;
    chk("fwft_empty", 8'(rempty_b), 8'd1);
    chk("fwft_count0", 8'(count_b), 8'd0);
    chk("fwft_err", {6'd0, overflow_b, underflow_b}, 8'b0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
